// File: rtl/outer_seq.sv
// outer_seq: outer-loop sequencer for the blitter.
//
// Launches one inner pass per outer iteration and pulses the outer counter's
// decrement enable after each pass. The counter's zero flag is sampled one
// cycle after the decrement (CHK) to decide whether another pass is needed.
// All outputs are registered.
//
// Optional feature: define OUTER_SEQ_STEP_EN to add single-step control.
// The FSM then parks in HOLD before every pass after the first, until step=1.
//
// Parameters:
//   PASS_W  width of the pass_cnt readback counter (wraps)
//   GAP     extra idle cycles between CHK and the next inner_start (0..15)
//
// Ports:
//   clk          system clock
//   resetl       asynchronous active-low reset
//   go           one-cycle start strobe
//   stop         level-sampled abort request
//   outer0       outer counter zero flag
//   inner_done   inner pass finished strobe
//   step         (OUTER_SEQ_STEP_EN only) release HOLD
//   held         (OUTER_SEQ_STEP_EN only) high while parked in HOLD
//   ocntena      one-cycle outer counter decrement enable
//   inner_start  one-cycle inner pass launch strobe
//   busy         run in progress
//   done_int     one-cycle completion strobe
//   aborted      one-cycle strobe when a run ends via stop
//   pass_cnt     inner passes completed in the current or last run
module outer_seq #(
    parameter int unsigned PASS_W = 16,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              go,
    input  logic              stop,
    input  logic              outer0,
    input  logic              inner_done,
`ifdef OUTER_SEQ_STEP_EN
    input  logic              step,
    output logic              held,
`endif
    output logic              ocntena,
    output logic              inner_start,
    output logic              busy,
    output logic              done_int,
    output logic              aborted,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StWait,
        StDec,
        StChk,
        StGapw,
        StDone,
        StAbort,
        StHold
    } state_e;

    // GAPW is entered with GAP-1 so that it lasts exactly GAP cycles.
    localparam logic [3:0] GapLoad = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    // State entered when another pass is required.
`ifdef OUTER_SEQ_STEP_EN
    localparam state_e StResume = StHold;
`else
    localparam state_e StResume = StStart;
`endif

    state_e            state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [3:0]        gap_q, gap_d;
    logic              ocntena_q, inner_start_q, busy_q, done_q, aborted_q, held_q;
    logic              active;

    assign active = (state_q == StStart) || (state_q == StWait) || (state_q == StDec) ||
                    (state_q == StChk) || (state_q == StGapw) || (state_q == StHold);

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (go && !stop) begin
                    pass_d  = '0;
                    state_d = outer0 ? StDone : StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (inner_done) begin
                    state_d = StDec;
                    pass_d  = pass_q + PASS_W'(1);
                end
            end
            StDec: state_d = StChk;
            StChk: begin
                if (outer0) begin
                    state_d = StDone;
                end else if (GAP == 0) begin
                    state_d = StResume;
                end else begin
                    state_d = StGapw;
                    gap_d   = GapLoad;
                end
            end
            StGapw: begin
                if (gap_q == 4'd0) begin
                    state_d = StResume;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
`ifdef OUTER_SEQ_STEP_EN
            StHold: begin
                if (step) begin
                    state_d = StStart;
                end
            end
`endif
            StDone, StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // stop overrides every other transition, including a pass completion.
        if (stop && active) begin
            state_d = StAbort;
            pass_d  = pass_q;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q       <= StIdle;
            pass_q        <= '0;
            gap_q         <= 4'd0;
            ocntena_q     <= 1'b0;
            inner_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pass_q        <= pass_d;
            gap_q         <= gap_d;
            // Outputs decode the state being entered, so they line up with it.
            ocntena_q     <= (state_d == StDec);
            inner_start_q <= (state_d == StStart);
            busy_q        <= (state_d != StIdle) && (state_d != StDone) &&
                             (state_d != StAbort);
            done_q        <= (state_d == StDone);
            aborted_q     <= (state_d == StAbort);
            held_q        <= (state_d == StHold);
        end
    end

    assign ocntena     = ocntena_q;
    assign inner_start = inner_start_q;
    assign busy        = busy_q;
    assign done_int    = done_q;
    assign aborted     = aborted_q;
    assign pass_cnt    = pass_q;
`ifdef OUTER_SEQ_STEP_EN
    assign held        = held_q;
`else
    logic unused_held;
    assign unused_held = held_q;
`endif

endmodule

// File: tb/tb_outer_seq.sv
// Bench for outer_seq: two instances (GAP=0 and GAP=4) each driven by a small
// environment model of the outer counter and the inner engine. Expected
// per-cycle outputs come from closed-form pass timing.
`timescale 1ns/1ps
module tb_outer_seq;

    localparam int N  = 80;
    localparam int G1 = 4;
`ifdef OUTER_SEQ_STEP_EN
    localparam int HX = 1;
`else
    localparam int HX = 0;
`endif
    // Bit positions of the observed output vector.
    localparam int BBusy = 5, BIs = 4, BOc = 3, BDn = 2, BAb = 1, BHd = 0;

    logic clk = 1'b0;
    logic resetl = 1'b0;
    logic go0 = 1'b0, go1 = 1'b0, stop0 = 1'b0, stop1 = 1'b0;
    logic idn0 = 1'b0, idn1 = 1'b0;
    logic step = 1'b1;
    int   cnt0 = 0, cnt1 = 0;
    logic z0, z1;
    logic oc0, is0, bz0, dn0, ab0, hd0;
    logic oc1, is1, bz1, dn1, ab1, hd1;
    logic [15:0] pc0, pc1;

    assign z0 = (cnt0 == 0);
    assign z1 = (cnt1 == 0);

    always #5 clk = ~clk;

    outer_seq #(.PASS_W(16), .GAP(0)) u_dut0 (
        .clk(clk), .resetl(resetl), .go(go0), .stop(stop0), .outer0(z0), .inner_done(idn0),
`ifdef OUTER_SEQ_STEP_EN
        .step(step), .held(hd0),
`endif
        .ocntena(oc0), .inner_start(is0), .busy(bz0), .done_int(dn0), .aborted(ab0),
        .pass_cnt(pc0)
    );

    outer_seq #(.PASS_W(16), .GAP(G1)) u_dut1 (
        .clk(clk), .resetl(resetl), .go(go1), .stop(stop1), .outer0(z1), .inner_done(idn1),
`ifdef OUTER_SEQ_STEP_EN
        .step(step), .held(hd1),
`endif
        .ocntena(oc1), .inner_start(is1), .busy(bz1), .done_int(dn1), .aborted(ab1),
        .pass_cnt(pc1)
    );

`ifndef OUTER_SEQ_STEP_EN
    assign hd0 = 1'b0;
    assign hd1 = 1'b0;
`endif

    int total = 0, bad = 0;
    int cur = 0, lat = 1, dly = 0, k_now = 0, done_drv = -1, spacing = -1;
    bit pend = 1'b0;
    int n_is = 0, n_oc = 0, n_dn = 0, n_ab = 0;
    logic [5:0]  vec;
    logic [15:0] pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock step: sample outputs after the edge, then advance the
    // environment (counter decrement one cycle after ocntena, inner engine).
    task automatic tick();
        logic idn;
        @(posedge clk);
        #1;
        k_now++;
        if (pend) begin
            if (cur == 0) begin
                if (cnt0 != 0) cnt0--;
            end else begin
                if (cnt1 != 0) cnt1--;
            end
            pend = 1'b0;
        end
        vec = (cur == 0) ? {bz0, is0, oc0, dn0, ab0, hd0} : {bz1, is1, oc1, dn1, ab1, hd1};
        pc  = (cur == 0) ? pc0 : pc1;
        if (vec[BOc]) pend = 1'b1;
        idn = 1'b0;
        if (dly != 0) begin
            dly--;
            if (dly == 0) begin
                idn = 1'b1;
                done_drv = k_now;
            end
        end
        if (vec[BIs]) begin
            dly = lat;
            if (done_drv >= 0) spacing = k_now - done_drv;
        end
        if (cur == 0) idn0 = idn; else idn1 = idn;
        n_is += int'(vec[BIs]);
        n_oc += int'(vec[BOc]);
        n_dn += int'(vec[BDn]);
        n_ab += int'(vec[BAb]);
    endtask

    task automatic env_reset(input int i, input int l, input int c);
        cur = i; lat = l; dly = 0; pend = 1'b0; done_drv = -1; spacing = -1;
        n_is = 0; n_oc = 0; n_dn = 0; n_ab = 0;
        idn0 = 1'b0; idn1 = 1'b0;
        if (i == 0) cnt0 = c; else cnt1 = c;
    endtask

    // Run with count c, inner latency l; optional one-cycle stop and stray go
    // at the given steps (step k is sampled by the DUT at edge k+1).
    task automatic run(input int i, input int c, input int l, input int stop_at,
                       input int go_at, input string nm);
        logic [5:0] ev [0:N];
        int ep [0:N];
        int g, per, s, d, last, ga;
        g    = (i == 1) ? G1 : 0;
        per  = l + 3 + g + HX;
        last = -10;
        for (int k = 0; k <= N; k++) begin
            ev[k] = '0;
            ep[k] = 0;
        end
        if (c == 0) begin
            ev[1][BDn] = 1'b1;
        end else begin
            for (int p = 0; p < c; p++) begin
                s = 1 + p * per;
                d = s + l + 1;
                ev[s][BIs] = 1'b1;
                ev[d][BOc] = 1'b1;
                for (int k = d; k <= N; k++) ep[k]++;
                if (p == c - 1) begin
                    ev[d + 2][BDn] = 1'b1;
                    last = d;
                end else if (HX != 0) begin
                    ev[d + 2 + g][BHd] = 1'b1;
                end
            end
        end
        for (int k = 1; k <= last + 1; k++) ev[k][BBusy] = 1'b1;
        if (stop_at >= 1 && stop_at < N && ev[stop_at][BBusy]) begin
            for (int k = stop_at + 1; k <= N; k++) begin
                ev[k] = '0;
                ep[k] = ep[stop_at];
            end
            ev[stop_at + 1][BAb] = 1'b1;
        end
        ga = (go_at >= 1 && go_at <= N && ev[go_at][BBusy]) ? go_at : -1;

        env_reset(i, l, c);
        tick();
        k_now = 0;
        if (i == 0) go0 = 1'b1; else go1 = 1'b1;
        for (int k = 1; k <= N; k++) begin
            tick();
            if (i == 0) begin
                go0 = (k == ga); stop0 = (k == stop_at);
            end else begin
                go1 = (k == ga); stop1 = (k == stop_at);
            end
            chk($sformatf("%s_vec@%0d", nm, k), 32'(vec), 32'(ev[k]));
            chk($sformatf("%s_pass@%0d", nm, k), 32'(pc), ep[k]);
        end
        go0 = 1'b0; go1 = 1'b0; stop0 = 1'b0; stop1 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int i, c, l, sa, ga;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec0", 32'({bz0, is0, oc0, dn0, ab0, hd0}), 0);
        chk("rst_pc0", 32'(pc0), 0);
        chk("rst_vec1", 32'({bz1, is1, oc1, dn1, ab1, hd1}), 0);
        #2 resetl = 1'b1;

        // Three passes, latency 5.
        run(0, 3, 5, -1, -1, "t1");
        chk("t1_starts", n_is, 3);
        chk("t1_decs", n_oc, 3);
        chk("t1_done", n_dn, 1);
        chk("t1_pc", 32'(pc0), 3);

        // Zero count finishes without passes.
        run(0, 0, 3, -1, -1, "t2");
        chk("t2_starts", n_is, 0);
        chk("t2_decs", n_oc, 0);
        chk("t2_done", n_dn, 1);

        // Abort in WAIT of pass 2.
        run(0, 2, 5, 11 + HX, -1, "t3");
        chk("t3_abort", n_ab, 1);
        chk("t3_done", n_dn, 0);
        chk("t3_decs", n_oc, 1);
        chk("t3_pc", 32'(pc0), 1);

        // GAP=4 spacing.
        run(1, 2, 3, -1, -1, "t4");
        chk("t4_spacing", spacing, 7 + HX);

        // Asynchronous reset mid-WAIT.
        env_reset(0, 6, 3);
        tick();
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        tick();
        tick();
        chk("t5_busy_pre", 32'(bz0), 1);
        #2 resetl = 1'b0;
        #1;
        chk("t5_async", 32'({bz0, is0, oc0, dn0, ab0, hd0}), 0);
        #3 resetl = 1'b1;
        run(0, 1, 2, -1, -1, "t5run");
        chk("t5_pc", 32'(pc0), 1);

        // go together with stop in IDLE is ignored.
        env_reset(0, 2, 2);
        tick();
        go0 = 1'b1; stop0 = 1'b1;
        tick();
        go0 = 1'b0; stop0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_idle@%0d", k), 32'(vec), 0);
        end
        chk("t6_pc_hold", 32'(pc0), 1);
        // Stray go while busy.
        run(0, 2, 4, -1, 5, "t6busy");
        chk("t6_done", n_dn, 1);
        chk("t6_pc", 32'(pc0), 2);

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            i  = int'($urandom_range(0, 1));
            c  = int'($urandom_range(0, 4));
            l  = int'($urandom_range(1, 6));
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 50)) : -1;
            ga = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 50)) : -1;
            run(i, c, l, sa, ga, $sformatf("r%0d", r));
        end

`ifdef OUTER_SEQ_STEP_EN
        // Single-step: parked in HOLD after pass 1 until step.
        step = 1'b0;
        env_reset(0, 2, 2);
        tick();
        k_now = 0;
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        repeat (5) tick();
        chk("t7_held", 32'({hd0, bz0}), 3);
        repeat (3) tick();
        chk("t7_still_held", 32'({hd0, is0}), 2);
        step = 1'b1;
        repeat (12) tick();
        chk("t7_done", n_dn, 1);
        chk("t7_pc", 32'(pc0), 2);
        chk("t7_released", 32'(hd0), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
